mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates between the instruction-fetch and load/store requesters for one shared, byte-addressed, single-port memory.
- The memory has a combinational read and writes a full 32-bit word on the clock edge.
- The block serialises accesses, aligns addresses to words, and does byte/halfword extraction on loads.
- Sub-word stores are done as read-modify-write, so the memory only ever sees word writes.

Parameters:
- ADDR_W, 32, address width of all request and memory address ports.
- MEM_BYTES, 64, memory size in bytes; an access whose word address is ≥ MEM_BYTES is an error.
- FIRST_PRIO, 0, requester favoured after reset: 0 = ifetch, 1 = lsu.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch request pending.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  fetch request accepted this cycle.
- if_resp_valid  out  1  one-cycle pulse; if_resp_data / if_resp_err are valid.
- if_resp_data  out  32  fetched instruction word.
- if_resp_err  out  1  misaligned or out-of-range fetch.
- ls_valid  in  1  load/store request pending.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal.
- ls_unsigned  in  1  loads: zero-extend instead of sign-extend.
- ls_addr  in  ADDR_W  byte address.
- ls_wdata  in  32  store data, right-aligned.
- ls_ready  out  1  load/store request accepted this cycle.
- ls_resp_valid  out  1  one-cycle completion pulse.
- ls_resp_data  out  32  extended load data; 0 for stores.
- ls_resp_err  out  1  misaligned, out-of-range or illegal size.
- mem_addr  out  ADDR_W  word-aligned address to the memory.
- mem_wen  out  1  word write strobe.
- mem_wdata  out  32  write word; byte lane i (bits 8i+7:8i) maps to mem_addr+i.
- mem_rdata  in  32  combinational read word, same lane mapping.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All ready, resp_valid, resp_err and mem_wen outputs are 0.
  - Resp data registers are 0; mem_addr is 0.
  - The round-robin pointer favours FIRST_PRIO.
  - Reset mid-transaction aborts it with no response and no further write; a write already strobed on a completed edge stands.
- Handshake:
  - x_ready is asserted combinationally only in IDLE, only for the granted requester, and only while its x_valid is high.
  - The transfer occurs on the edge where valid && ready; request fields are latched then.
  - The requester holds fields stable while valid && !ready.
  - Responses have no backpressure.
  - A requester must not present a new request before its previous response.
- Arbitration (IDLE):
  - One valid requester: it is granted.
  - Both valid: the requester not granted last is granted (round-robin).
  - The pointer updates only on grant.
- FSM states: IDLE, LOAD, STORE_R, STORE_W, RESP.
- IDLE transitions on grant:
  - error → RESP with err=1; no memory access.
  - load or fetch → LOAD.
  - word store → STORE_W.
  - byte/half store → STORE_R.
- Error checks (any one → error):
  - half access with addr[0]=1.
  - word access or fetch with addr[1:0]≠0.
  - ls_size=3.
  - {addr[ADDR_W-1:2],2'b00} + 4 > MEM_BYTES.
- LOAD:
  - mem_addr = aligned address, mem_wen=0.
  - Capture mem_rdata on the edge, select lanes by addr[1:0], sign- or zero-extend (fetch is a raw word).
  - → RESP.
- STORE_R:
  - mem_addr = aligned address.
  - Capture mem_rdata, merge the new byte/half into lane(s) addr[1:0].
  - → STORE_W.
- STORE_W:
  - mem_wen=1 for exactly one cycle; mem_wdata = merged word (word store: ls_wdata as-is).
  - → RESP.
- RESP: the latched requester's resp_valid=1 for one cycle → IDLE. The next grant can happen the following cycle.
- Latency from the accept edge (cycle 0) to resp_valid:
  - load or fetch: cycle 2.
  - word store: 2.
  - sub-word store: 3.
  - error: 1.
- Idle outputs: mem_wen=0 except in STORE_W. mem_addr holds its last value when idle.
- Resp data holds its value between pulses.

Decomposition:
- Shared package holds:
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2.
  - state encoding.
  - requester ID constants REQ_IF=0, REQ_LS=1.
- One sub-module, mem_lane_align (combinational), handles:
  - load extraction and extension, from (word, offset, size, unsigned).
  - store merging, from (old word, new data, offset, size).

Test Plan:
- Fetch, if_addr=0x8, mem word 0xE8A50000 → if_ready at cycle 0; mem_addr=0x8 in cycle 1; if_resp_valid at cycle 2 with 0xE8A50000, err=0.
- Both valid in the same cycle after reset with FIRST_PRIO=0 → ifetch granted first, lsu granted in the cycle after the fetch RESP. Then both valid again → lsu is not granted; ifetch wins, confirming the pointer rotates.
- Store byte 0xAB at 0x11 over word 0x44332211 → STORE_R, STORE_W; mem_wen=1 once at mem_addr=0x10 with mem_wdata=0x4433AB11; ls_resp_valid at cycle 3.
- Load byte at 0x12 from word 0x00800000, signed → resp 0xFFFFFF80; same load with unsigned → 0x00000080.
- Load word at 0x6, half at 0x3, size=3, or address 0x40 (MEM_BYTES=64) → ls_resp_err=1 at cycle 1; mem_wen stays 0.
- reset_n pulsed low during STORE_R → no mem_wen and no resp afterwards; state is IDLE, outputs 0, next request is serviced normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the fetch/load-store memory arbiter
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_R,
        STORE_W,
        RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte/half lane extraction for loads and lane merging for stores
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = rword >> shamt;

    always_comb begin
        load_data = rword;
        case (size)
            SZ_B:    load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_data = rword;
        endcase
    end

    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        case (size)
            SZ_B:    lane_mask = 32'h0000_00FF << shamt;
            SZ_H:    lane_mask = 32'h0000_FFFF << shamt;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        merged = (rword & ~lane_mask) | ((wdata << shamt) & lane_mask);
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter serialising fetch and load/store onto one word memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_BYTES  = 64,
    parameter int FIRST_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_data,
    output logic              if_resp_err,
    input  logic              ls_valid,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic              ls_resp_valid,
    output logic [31:0]       ls_resp_data,
    output logic              ls_resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t state, next_state;

    logic              prio;
    logic              gnt_valid, gnt_id, accept;
    logic [ADDR_W-1:0] g_addr;
    logic [1:0]        g_size;
    logic              g_we, g_err;
    logic [ADDR_W:0]   end_addr;

    logic              req_id, req_uns, req_err;
    logic [1:0]        req_size, req_off;
    logic [31:0]       req_wdata;
    logic [31:0]       load_data, merged;

    always_comb begin
        gnt_valid = if_valid | ls_valid;
        if (if_valid && ls_valid) gnt_id = prio;
        else                      gnt_id = ls_valid ? REQ_LS : REQ_IF;
        g_addr   = (gnt_id == REQ_LS) ? ls_addr : if_addr;
        g_size   = (gnt_id == REQ_LS) ? ls_size : SZ_W;
        g_we     = (gnt_id == REQ_LS) & ls_we;
        // one extra bit so an aligned address near the top cannot wrap past the limit
        end_addr = {1'b0, g_addr[ADDR_W-1:2], 2'b00} + (ADDR_W+1)'(4);
        g_err    = (g_size == 2'd3)
                 | ((g_size == SZ_H) & g_addr[0])
                 | ((g_size == SZ_W) & (|g_addr[1:0]))
                 | (end_addr > (ADDR_W+1)'(MEM_BYTES));
        accept   = (state == IDLE) & gnt_valid;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (g_err)               next_state = RESP;
                    else if (!g_we)          next_state = LOAD;
                    else if (g_size == SZ_W) next_state = STORE_W;
                    else                     next_state = STORE_R;
                end
            end
            LOAD:    next_state = RESP;
            STORE_R: next_state = STORE_W;
            STORE_W: next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        if_ready      = (state == IDLE) & (gnt_id == REQ_IF) & if_valid;
        ls_ready      = (state == IDLE) & (gnt_id == REQ_LS) & ls_valid;
        if_resp_valid = (state == RESP) & (req_id == REQ_IF);
        ls_resp_valid = (state == RESP) & (req_id == REQ_LS);
        if_resp_err   = if_resp_valid & req_err;
        ls_resp_err   = ls_resp_valid & req_err;
        mem_wen       = (state == STORE_W);
    end

    mem_lane_align u_align (
        .rword      (mem_rdata),
        .wdata      (req_wdata),
        .offset     (req_off),
        .size       (req_size),
        .is_unsigned(req_uns),
        .load_data  (load_data),
        .merged     (merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio         <= (FIRST_PRIO != 0);
            req_id       <= REQ_IF;
            req_uns      <= 1'b0;
            req_err      <= 1'b0;
            req_size     <= SZ_W;
            req_off      <= 2'd0;
            req_wdata    <= 32'd0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            if_resp_data <= 32'd0;
            ls_resp_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prio      <= ~gnt_id;
                        req_id    <= gnt_id;
                        req_uns   <= (gnt_id == REQ_LS) & ls_unsigned;
                        req_err   <= g_err;
                        req_size  <= g_size;
                        req_off   <= g_addr[1:0];
                        req_wdata <= ls_wdata;
                        // rejected requests never touch the memory port
                        if (!g_err) begin
                            mem_addr <= {g_addr[ADDR_W-1:2], 2'b00};
                            if (g_we && g_size == SZ_W) mem_wdata <= ls_wdata;
                        end
                    end
                end
                LOAD: begin
                    if (req_id == REQ_LS) ls_resp_data <= load_data;
                    else                  if_resp_data <= load_data;
                end
                STORE_R: mem_wdata    <= merged;
                STORE_W: ls_resp_data <= 32'd0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random checks of mem_arbiter against a byte-array model
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_valid = 1'b0, ls_valid = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [1:0]  ls_size = 2'd0;
    logic        if_ready, if_resp_valid, if_resp_err;
    logic        ls_ready, ls_resp_valid, ls_resp_err, mem_wen;
    logic [31:0] if_resp_data, ls_resp_data, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dev_mem [0:15];
    logic [7:0]  ref_mem [0:63];

    int total = 0;
    int bad = 0;

    int          r_lat, r_wens, e_lat, e_wens;
    logic [31:0] r_data, r_wa, r_wd, e_data;
    logic        r_err, e_err, r_after;

    mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = dev_mem[mem_addr[5:2]];

    always @(posedge clock) begin
        if (mem_wen && mem_addr < 32'd64) dev_mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        dev_mem[idx] = val;
        for (int i = 0; i < 4; i++) ref_mem[idx*4+i] = val[8*i +: 8];
    endtask

    function automatic logic [31:0] rd_word(input int idx);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[idx*4+i];
        return v;
    endfunction

    // Expected outcome of one request from the byte-addressed memory rules.
    task automatic model(input bit is_if, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        longint      a;
        int          n;
        logic [31:0] v, m;
        a = addr;
        n = is_if ? 4 : (1 << size);
        e_err  = (!is_if && size == 2'd3) || (a % n != 0) || ((a / 4) * 4 + 4 > 64);
        e_wens = (!is_if && we && !e_err) ? 1 : 0;
        if (e_err)               e_lat = 1;
        else if (is_if || !we)   e_lat = 2;
        else                     e_lat = (n == 4) ? 2 : 3;
        e_data = 32'd0;
        if (!e_err) begin
            if (is_if || !we) begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
                m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
                if (!is_if && !uns && n < 4 && v[8*n-1]) v = v | ~m;
                e_data = v;
            end else begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic do_req(input bit is_if, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int n;
        bit acc, done;
        if (is_if) begin
            if_valid = 1'b1; if_addr = addr;
        end else begin
            ls_valid = 1'b1; ls_we = we; ls_size = size; ls_unsigned = uns;
            ls_addr = addr; ls_wdata = wd;
        end
        acc = 1'b0; n = 0;
        while (!acc && n < 20) begin
            @(negedge clock);
            acc = is_if ? if_ready : ls_ready;
            @(posedge clock); #1;
            n++;
        end
        if_valid = 1'b0; ls_valid = 1'b0;
        r_lat = acc ? 1 : 99; r_wens = 0; r_data = 'x; r_err = 1'bx; done = 1'b0;
        while (acc && !done && r_lat < 10) begin
            @(negedge clock);
            if (mem_wen) begin r_wens++; r_wa = mem_addr; r_wd = mem_wdata; end
            if (is_if ? if_resp_valid : ls_resp_valid) begin
                done = 1'b1;
                r_data = is_if ? if_resp_data : ls_resp_data;
                r_err  = is_if ? if_resp_err  : ls_resp_err;
            end else begin
                @(posedge clock); #1;
                r_lat++;
            end
        end
        @(posedge clock); #1;
        r_after = if_resp_valid | ls_resp_valid;
    endtask

    task automatic run_req(input string tag, input bit is_if, input bit we, input logic [1:0] size,
                           input bit uns, input logic [31:0] addr, input logic [31:0] wd);
        model(is_if, we, size, uns, addr, wd);
        do_req(is_if, we, size, uns, addr, wd);
        chk({tag, "_lat"}, r_lat, e_lat);
        chk({tag, "_err"}, r_err, e_err);
        if (!e_err) chk({tag, "_data"}, r_data, e_data);
        chk({tag, "_wens"}, r_wens, e_wens);
        chk({tag, "_pulse"}, r_after, 1'b0);
    endtask

    initial begin
        bit          ri, rw, ru;
        logic [1:0]  rs;
        logic [31:0] ra;
        int          wcnt, rcnt;

        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        set_word(2, 32'hE8A5_0000);

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ctl", {if_ready, ls_ready, if_resp_valid, ls_resp_valid,
                          if_resp_err, ls_resp_err, mem_wen}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_if_data", if_resp_data, 32'd0);
        chk("reset_ls_data", ls_resp_data, 32'd0);
        reset_n = 1'b1;

        // both requesters valid straight after reset; fetch is favoured first
        @(posedge clock); #1;
        if_valid = 1'b1; if_addr = 32'h8;
        ls_valid = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_addr = 32'h4;
        @(negedge clock);
        chk("arb_c0_if_ready", if_ready, 1'b1);
        chk("arb_c0_ls_ready", ls_ready, 1'b0);
        @(posedge clock); #1; if_valid = 1'b0;
        @(negedge clock);
        chk("fetch_c1_mem_addr", mem_addr, 32'h8);
        chk("fetch_c1_wen", mem_wen, 1'b0);
        chk("fetch_c1_ls_ready", ls_ready, 1'b0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("fetch_c2_valid", if_resp_valid, 1'b1);
        chk("fetch_c2_data", if_resp_data, 32'hE8A5_0000);
        chk("fetch_c2_err", if_resp_err, 1'b0);
        @(posedge clock); #1; if_valid = 1'b1; if_addr = 32'h0;
        @(negedge clock);
        chk("rr_c3_ls_ready", ls_ready, 1'b1);
        chk("rr_c3_if_ready", if_ready, 1'b0);
        @(posedge clock); #1; ls_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rr_ls_resp", ls_resp_valid, 1'b1);
        chk("rr_ls_data", ls_resp_data, rd_word(1));
        @(posedge clock); #1; ls_valid = 1'b1; ls_addr = 32'hC;
        @(negedge clock);
        chk("rr_c6_if_ready", if_ready, 1'b1);
        chk("rr_c6_ls_ready", ls_ready, 1'b0);
        @(posedge clock); #1; if_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rr_if_resp", if_resp_valid, 1'b1);
        chk("rr_if_data", if_resp_data, rd_word(0));
        @(posedge clock); #1;
        @(negedge clock);
        chk("rr_c9_ls_ready", ls_ready, 1'b1);
        @(posedge clock); #1; ls_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rr_ls2_resp", ls_resp_valid, 1'b1);
        chk("rr_ls2_data", ls_resp_data, rd_word(3));
        @(posedge clock); #1;

        set_word(4, 32'h4433_2211);
        run_req("sb_0x11", 1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
        chk("sb_wr_addr", r_wa, 32'h10);
        chk("sb_wr_data", r_wd, 32'h4433_AB11);
        chk("sb_resp_data", r_data, 32'd0);

        set_word(4, 32'h0080_0000);
        run_req("lb_signed", 1'b0, 1'b0, 2'd0, 1'b0, 32'h12, 32'd0);
        chk("lb_signed_val", r_data, 32'hFFFF_FF80);
        run_req("lb_unsigned", 1'b0, 1'b0, 2'd0, 1'b1, 32'h12, 32'd0);
        chk("lb_unsigned_val", r_data, 32'h0000_0080);

        run_req("err_lw_6", 1'b0, 1'b0, 2'd2, 1'b0, 32'h6, 32'd0);
        run_req("err_lh_3", 1'b0, 1'b0, 2'd1, 1'b0, 32'h3, 32'd0);
        run_req("err_sz3", 1'b0, 1'b0, 2'd3, 1'b0, 32'h0, 32'd0);
        run_req("err_lw_40", 1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
        run_req("err_sw_wrap", 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);
        run_req("err_if_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h2, 32'd0);
        run_req("sw_last", 1'b0, 1'b1, 2'd2, 1'b0, 32'h3C, 32'hCAFE_F00D);
        run_req("sh_hi", 1'b0, 1'b1, 2'd1, 1'b0, 32'h3E, 32'h0000_BEEF);
        run_req("lh_hi", 1'b0, 1'b0, 2'd1, 1'b0, 32'h3E, 32'd0);

        // reset arriving while the read half of a byte store is in flight
        set_word(5, 32'h1122_3344);
        ls_valid = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_unsigned = 1'b0;
        ls_addr = 32'h15; ls_wdata = 32'h55;
        @(negedge clock);
        chk("rst_c0_ready", ls_ready, 1'b1);
        @(posedge clock); #1;
        ls_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_ctl", {ls_ready, ls_resp_valid, ls_resp_err, mem_wen}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        wcnt = 0; rcnt = 0;
        repeat (5) begin
            @(negedge clock);
            if (mem_wen) wcnt++;
            if (ls_resp_valid || if_resp_valid) rcnt++;
        end
        chk("rst_no_write", wcnt, 0);
        chk("rst_no_resp", rcnt, 0);
        chk("rst_mem_kept", dev_mem[5], 32'h1122_3344);
        @(posedge clock); #1;
        run_req("post_rst_lw", 1'b0, 1'b0, 2'd2, 1'b0, 32'h14, 32'd0);

        for (int k = 0; k < 40; k++) begin
            ri = ($urandom_range(0, 3) == 0);
            rw = ri ? 1'b0 : 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ru = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(64, 80)) : 32'($urandom_range(0, 63));
            if (ri && $urandom_range(0, 3) != 0) ra = ra & 32'hFFFF_FFFC;
            run_req($sformatf("rnd%0d", k), ri, rw, rs, ru, ra, $urandom);
        end

        for (int i = 0; i < 16; i++) chk($sformatf("final_word%0d", i), dev_mem[i], rd_word(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
